arp_tx_sched: RTL and testbench
===============================

Name: arp_tx_sched

Overview:
Schedules the ARP frame sender between two requesters: the RX path, which needs ARP replies, and the host, which issues ARP queries. The block latches the winning request's operands and drives the sender's start level. It then waits for the sender to reach END, drops start, and enforces an inter-frame gap before the next grant. It sits between the ARP receive parser/host CSR logic and the block-sequenced ARP transmit datapath.

Parameters:
IFG_CYCLES, 12, idle cycles inserted after sender returns to IDLE before next start (>=1)
ACK_TIMEOUT, 1024, cycles allowed from start assertion to first-block ack before abort
CNT_W, 11, width of shared gap/timeout counter; must hold max(IFG_CYCLES, ACK_TIMEOUT)

Ports:
clk  in  1  clock
areset  in  1  reset, synchronous, active-high
rep_req  in  1  RX path requests ARP reply; held until rep_gnt
rep_mac  in  48  reply target MAC, valid with rep_req
rep_ip  in  32  reply target IP, valid with rep_req
rep_gnt  out  1  one-cycle pulse: reply request accepted
qry_req  in  1  host requests ARP query; held until qry_gnt
qry_ip  in  32  IP to resolve, valid with qry_req
qry_gnt  out  1  one-cycle pulse: query request accepted
tx_start  out  1  level start to sender; high from launch until tx_end seen
tx_op  out  16  ARP opcode: 16'h0001 query, 16'h0002 reply
tx_dst_mac  out  48  ETH/ARP dest MAC (query: FF..FF eth, 00..00 ARP target)
tx_dst_ip  out  32  ARP dest IP
tx_ack  in  1  sender accepted first ETH_DEST_ADDR block
tx_end  in  1  sender is in END state
busy  out  1  high in any state except IDLE
err_timeout  out  1  one-cycle pulse on ack timeout abort

Behaviour:
- Reset: state IDLE; tx_start, rep_gnt, qry_gnt, busy, err_timeout = 0; tx_op, tx_dst_mac, tx_dst_ip = 0; counter = 0; rr pointer = reply.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_END, DRAIN, GAP.
- IDLE: if any req, select winner (fixed priority: reply over query). Same cycle: register operands and opcode, pulse that gnt, go LAUNCH. Grant is registered, so gnt appears the cycle after req is first sampled with IDLE.
- LAUNCH: tx_start=1, counter cleared; -> WAIT_ACK.
- WAIT_ACK: tx_start=1. tx_ack -> WAIT_END. Counter reaching ACK_TIMEOUT-1 without ack -> drop tx_start, pulse err_timeout, -> GAP. Ack on the same cycle as the timeout: ack wins.
- WAIT_END: tx_start=1 until tx_end sampled high; then tx_start=0 -> DRAIN. No timeout here.
- DRAIN: tx_start=0; wait for tx_end low (sender back to IDLE); counter cleared -> GAP.
- GAP: count IFG_CYCLES cycles; then -> IDLE. Requests arriving during GAP stay pending; no grant before IDLE.
- Operand registers hold their values from grant until the next grant. The sender samples them while tx_start is high.
- Query operands: tx_dst_mac = 48'hFFFF_FFFF_FFFF.
- Requester dropping req before gnt is legal: no grant, no side effects.
- areset mid-frame: everything returns to reset values next edge; tx_start drops, and the sender's own reset is expected concurrently.
- Counter saturates; never wraps.

Optional Feature:
ARB_RR_EN: when defined, arbitration is round-robin. A one-bit pointer favours the requester not granted last; the pointer updates on each grant, and a lone requester always wins. When undefined, fixed priority applies (reply first) and the pointer logic is absent.

Test Plan:
- Single reply: rep_req=1, rep_mac=0x0011_2233_4455, rep_ip=0x0A00_0001 -> rep_gnt one pulse; tx_op=0x0002; tx_start high until tx_end; 12 idle cycles after tx_end falls before busy=0.
- Single query: qry_ip=0xC0A8_0101 -> tx_op=0x0001, tx_dst_mac=FFFF_FFFF_FFFF, tx_dst_ip=0xC0A8_0101.
- Simultaneous rep_req and qry_req held for 3 frames -> fixed: reply,reply,reply; with ARB_RR_EN: reply,query,reply.
- No tx_ack -> err_timeout pulses exactly 1024 cycles after tx_start rises; tx_start falls the same edge; GAP then IDLE.
- qry_req asserted during GAP -> qry_gnt only after GAP completes; no tx_start during gap.
- areset asserted in WAIT_END -> next cycle tx_start=0, busy=0, all operands 0; a pending req is granted once areset deasserts.

Source files
------------

// File: rtl/arp_tx_sched.sv
// rtl/arp_tx_sched.sv - ARP transmit scheduler arbitrating RX replies and host queries onto one sender
// Build option: define ARB_RR_EN for round-robin arbitration; default is fixed priority (reply first).
module arp_tx_sched #(
   parameter int IFG_CYCLES  = 12,
   parameter int ACK_TIMEOUT = 1024,
   parameter int CNT_W       = 11
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        rep_req,
   input  logic [47:0] rep_mac,
   input  logic [31:0] rep_ip,
   output logic        rep_gnt,
   input  logic        qry_req,
   input  logic [31:0] qry_ip,
   output logic        qry_gnt,
   output logic        tx_start,
   output logic [15:0] tx_op,
   output logic [47:0] tx_dst_mac,
   output logic [31:0] tx_dst_ip,
   input  logic        tx_ack,
   input  logic        tx_end,
   output logic        busy,
   output logic        err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACK,
      S_WAIT_END,
      S_DRAIN,
      S_GAP
   } state_t;

   localparam logic [15:0]      OP_QUERY   = 16'h0001;
   localparam logic [15:0]      OP_REPLY   = 16'h0002;
   localparam logic [47:0]      MAC_BCAST  = 48'hFFFF_FFFF_FFFF;
   localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IFG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              tx_start_q, tx_start_d;
   logic              rep_gnt_q, rep_gnt_d;
   logic              qry_gnt_q, qry_gnt_d;
   logic              err_timeout_q, err_timeout_d;
   logic [15:0]       tx_op_q, tx_op_d;
   logic [47:0]       tx_dst_mac_q, tx_dst_mac_d;
   logic [31:0]       tx_dst_ip_q, tx_dst_ip_d;

   logic              win_rep;
   logic              win_qry;

   // Shared gap/timeout counter increments but sticks at all-ones instead of wrapping.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef ARB_RR_EN
   // rr_q = 1 means the query side is favoured because reply won last.
   logic rr_q, rr_d;

   // Round-robin winner select; a lone requester always wins.
   always_comb begin
      win_rep = rep_req && (!qry_req || !rr_q);
      win_qry = qry_req && (!rep_req || rr_q);
   end

   // Pointer flips toward the other requester on every grant.
   always_comb begin
      rr_d = rr_q;
      if (state_q == S_IDLE) begin
         if (win_rep) begin
            rr_d = 1'b1;
         end else if (win_qry) begin
            rr_d = 1'b0;
         end
      end
   end

   // Pointer register, reset to favour the reply path.
   always_ff @(posedge clk) begin
      if (areset) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   // Fixed priority winner select: reply always beats query.
   always_comb begin
      win_rep = rep_req;
      win_qry = qry_req && !rep_req;
   end
`endif

   // Next-state, counter and registered-output logic for the launch/ack/end/gap sequence.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tx_start_d    = tx_start_q;
      rep_gnt_d     = 1'b0;
      qry_gnt_d     = 1'b0;
      err_timeout_d = 1'b0;
      tx_op_d       = tx_op_q;
      tx_dst_mac_d  = tx_dst_mac_q;
      tx_dst_ip_d   = tx_dst_ip_q;

      case (state_q)
         S_IDLE: begin
            // Grant and operand capture happen on the same edge; start rises with them
            // so the sender sees stable operands for the whole time start is high.
            if (win_rep) begin
               rep_gnt_d    = 1'b1;
               tx_op_d      = OP_REPLY;
               tx_dst_mac_d = rep_mac;
               tx_dst_ip_d  = rep_ip;
               tx_start_d   = 1'b1;
               cnt_d        = '0;
               state_d      = S_LAUNCH;
            end else if (win_qry) begin
               qry_gnt_d    = 1'b1;
               tx_op_d      = OP_QUERY;
               tx_dst_mac_d = MAC_BCAST;
               tx_dst_ip_d  = qry_ip;
               tx_start_d   = 1'b1;
               cnt_d        = '0;
               state_d      = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            // Counter was cleared on entry; the launch cycle counts toward the ack budget
            // so the abort lands exactly ACK_TIMEOUT cycles after start rose.
            tx_start_d = 1'b1;
            cnt_d      = cnt_inc;
            state_d    = S_WAIT_ACK;
         end

         S_WAIT_ACK: begin
            tx_start_d = 1'b1;
            if (tx_ack) begin
               // Ack takes precedence over a coincident timeout.
               state_d = S_WAIT_END;
            end else if (cnt_q >= ACK_LAST) begin
               tx_start_d    = 1'b0;
               err_timeout_d = 1'b1;
               cnt_d         = '0;
               state_d       = S_GAP;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         S_WAIT_END: begin
            if (tx_end) begin
               tx_start_d = 1'b0;
               state_d    = S_DRAIN;
            end
         end

         S_DRAIN: begin
            tx_start_d = 1'b0;
            if (!tx_end) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            tx_start_d = 1'b0;
            if (cnt_q >= GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            tx_start_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State and output registers; areset returns everything to idle with cleared operands.
   always_ff @(posedge clk) begin
      if (areset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         tx_start_q    <= 1'b0;
         rep_gnt_q     <= 1'b0;
         qry_gnt_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         tx_op_q       <= '0;
         tx_dst_mac_q  <= '0;
         tx_dst_ip_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tx_start_q    <= tx_start_d;
         rep_gnt_q     <= rep_gnt_d;
         qry_gnt_q     <= qry_gnt_d;
         err_timeout_q <= err_timeout_d;
         tx_op_q       <= tx_op_d;
         tx_dst_mac_q  <= tx_dst_mac_d;
         tx_dst_ip_q   <= tx_dst_ip_d;
      end
   end

   assign rep_gnt     = rep_gnt_q;
   assign qry_gnt     = qry_gnt_q;
   assign tx_start    = tx_start_q;
   assign tx_op       = tx_op_q;
   assign tx_dst_mac  = tx_dst_mac_q;
   assign tx_dst_ip   = tx_dst_ip_q;
   assign err_timeout = err_timeout_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_arp_tx_sched.sv
// tb/tb_arp_tx_sched.sv - directed scoreboard bench for arp_tx_sched
module tb_arp_tx_sched;

   localparam int          IFG     = 12;
   localparam int          ACK_TO  = 1024;
   localparam logic [47:0] REP_MAC = 48'h0011_2233_4455;
   localparam logic [31:0] REP_IP  = 32'h0A00_0001;
   localparam logic [31:0] QRY_IP  = 32'hC0A8_0101;
   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

   logic        clk;
   logic        areset;
   logic        rep_req;
   logic [47:0] rep_mac;
   logic [31:0] rep_ip;
   logic        rep_gnt;
   logic        qry_req;
   logic [31:0] qry_ip;
   logic        qry_gnt;
   logic        tx_start;
   logic [15:0] tx_op;
   logic [47:0] tx_dst_mac;
   logic [31:0] tx_dst_ip;
   logic        tx_ack;
   logic        tx_end;
   logic        busy;
   logic        err_timeout;

   typedef struct packed {
      logic [1:0]  which;
      logic [15:0] op;
      logic [47:0] mac;
      logic [31:0] ip;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;

   arp_tx_sched dut (
      .clk         (clk),
      .areset      (areset),
      .rep_req     (rep_req),
      .rep_mac     (rep_mac),
      .rep_ip      (rep_ip),
      .rep_gnt     (rep_gnt),
      .qry_req     (qry_req),
      .qry_ip      (qry_ip),
      .qry_gnt     (qry_gnt),
      .tx_start    (tx_start),
      .tx_op       (tx_op),
      .tx_dst_mac  (tx_dst_mac),
      .tx_dst_ip   (tx_dst_ip),
      .tx_ack      (tx_ack),
      .tx_end      (tx_end),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // which: 1 = reply, 2 = query; operands taken from the bench's own stimulus values
   task automatic push_exp(input logic [1:0] which);
      exp_t e;
      e.which = which;
      if (which == 2'd1) begin
         e.op  = 16'h0002;
         e.mac = rep_mac;
         e.ip  = rep_ip;
      end else begin
         e.op  = 16'h0001;
         e.mac = BCAST;
         e.ip  = qry_ip;
      end
      sb.push_back(e);
   endtask

   task automatic take_grant(input string tag, input int exp_lat, input bit release_reqs);
      int   lat;
      int   which;
      exp_t e;
      lat = 0;
      which = 0;
      while (!(rep_gnt === 1'b1 || qry_gnt === 1'b1) && lat < 2000) begin
         cyc();
         lat++;
      end
      if (rep_gnt === 1'b1) which = 1;
      else if (qry_gnt === 1'b1) which = 2;
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_who"}, which, e.which);
      check({tag, "_op"}, tx_op, e.op);
      check({tag, "_mac"}, tx_dst_mac, e.mac);
      check({tag, "_ip"}, tx_dst_ip, e.ip);
      check({tag, "_start"}, tx_start, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      if (release_reqs) begin
         rep_req = 1'b0;
         qry_req = 1'b0;
      end
   endtask

   // Sender model for a normal frame, entered on the grant cycle.
   task automatic finish_frame(input bit gap_qry);
      int n;
      int quiet_bad;
      cyc();
      check("gnt_one_pulse", {rep_gnt, qry_gnt}, 2'b00);
      tx_ack = 1'b1;
      cyc();
      tx_ack = 1'b0;
      cyc();
      cyc();
      check("start_held", tx_start, 1'b1);
      tx_end = 1'b1;
      n = 0;
      while (tx_start === 1'b1 && n < 32) begin
         cyc();
         n++;
      end
      check("start_drop", n, 1);
      cyc();
      cyc();
      check("start_low_drain", tx_start, 1'b0);
      tx_end = 1'b0;
      if (gap_qry) begin
         qry_ip = QRY_IP;
         qry_req = 1'b1;
         push_exp(2'd2);
      end
      n = 0;
      quiet_bad = 0;
      while (busy === 1'b1 && n < 64) begin
         cyc();
         n++;
         if (tx_start !== 1'b0 || rep_gnt !== 1'b0 || qry_gnt !== 1'b0) quiet_bad++;
      end
      // one cycle for DRAIN to see tx_end low, then IFG gap cycles
      check("gap_len", n, IFG + 1);
      check("gap_quiet", quiet_bad, 0);
   endtask

   initial begin
      int n;
      int early_drop;
      areset  = 1'b1;
      rep_req = 1'b0;
      rep_mac = REP_MAC;
      rep_ip  = REP_IP;
      qry_req = 1'b0;
      qry_ip  = QRY_IP;
      tx_ack  = 1'b0;
      tx_end  = 1'b0;
      repeat (3) cyc();
      check("rst_start", tx_start, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_gnt", {rep_gnt, qry_gnt}, 2'b00);
      check("rst_err", err_timeout, 1'b0);
      check("rst_op", tx_op, 16'h0);
      check("rst_mac", tx_dst_mac, 48'h0);
      check("rst_ip", tx_dst_ip, 32'h0);
      areset = 1'b0;
      cyc();

      // single reply
      rep_req = 1'b1;
      push_exp(2'd1);
      take_grant("rep1", 1, 1'b1);
      finish_frame(1'b0);

      // single query
      qry_req = 1'b1;
      push_exp(2'd2);
      take_grant("qry1", 1, 1'b1);
      finish_frame(1'b0);

      // both requesters held across three frames
      rep_req = 1'b1;
      qry_req = 1'b1;
`ifdef ARB_RR_EN
      push_exp(2'd1);
      push_exp(2'd2);
      push_exp(2'd1);
`else
      push_exp(2'd1);
      push_exp(2'd1);
      push_exp(2'd1);
`endif
      take_grant("arb1", 1, 1'b0);
      finish_frame(1'b0);
      take_grant("arb2", 1, 1'b0);
      finish_frame(1'b0);
      take_grant("arb3", 1, 1'b1);
      finish_frame(1'b0);

      // no ack: abort after ACK_TO cycles of start
      qry_req = 1'b1;
      push_exp(2'd2);
      take_grant("to", 1, 1'b1);
      n = 0;
      early_drop = 0;
      while (err_timeout !== 1'b1 && n < ACK_TO + 50) begin
         cyc();
         n++;
         if (err_timeout !== 1'b1 && tx_start !== 1'b1) early_drop++;
      end
      check("to_lat", n, ACK_TO);
      check("to_start_fall", tx_start, 1'b0);
      check("to_start_held", early_drop, 0);
      cyc();
      check("to_err_pulse", err_timeout, 1'b0);
      n = 1;
      while (busy === 1'b1 && n < 64) begin
         cyc();
         n++;
      end
      check("to_gap_len", n, IFG);

      // query raised during the gap waits for IDLE
      rep_req = 1'b1;
      push_exp(2'd1);
      take_grant("gap_rep", 1, 1'b1);
      finish_frame(1'b1);
      take_grant("gap_qry", 1, 1'b1);
      finish_frame(1'b0);

      // areset while waiting for tx_end, with a query pending
      rep_req = 1'b1;
      push_exp(2'd1);
      take_grant("rst_rep", 1, 1'b1);
      cyc();
      tx_ack = 1'b1;
      cyc();
      tx_ack = 1'b0;
      cyc();
      check("rst_pre_start", tx_start, 1'b1);
      qry_req = 1'b1;
      push_exp(2'd2);
      areset = 1'b1;
      cyc();
      check("mid_rst_start", tx_start, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_op", tx_op, 16'h0);
      check("mid_rst_mac", tx_dst_mac, 48'h0);
      check("mid_rst_ip", tx_dst_ip, 32'h0);
      check("mid_rst_gnt", {rep_gnt, qry_gnt}, 2'b00);
      areset = 1'b0;
      take_grant("post_rst", 1, 1'b1);
      finish_frame(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
